// File: rtl/serial_frame_rx.sv
//------------------------------------------------------------------------------
// serial_frame_rx : framed serial receiver (start/data/stop) with valid/ready
//                   output port. Optional parity: SERIAL_FRAME_RX_PARITY_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_frame_rx #(
   parameter int DATA_W    = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              serial_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              frame_err,
   output logic              overrun,
   input  logic              overrun_clr,
`ifdef SERIAL_FRAME_RX_PARITY_EN
   output logic              parity_err,
`endif
   output logic              busy
);

   localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
   localparam logic [1:0] PARITY = 2'd2;
`endif
   localparam logic [1:0] STOP   = 2'd3;

   logic [1:0]        state;
   logic [CNT_W-1:0]  bitCnt;
   logic [DATA_W-1:0] shiftReg;
   logic [DATA_W-1:0] shiftNext;
   logic              commitGood;
   logic              commitBad;
   logic              parityFail;
   logic              accept;

`ifdef SERIAL_FRAME_RX_PARITY_EN
   logic parityBad;
   logic commitParityBad;
   assign parityFail = parityBad;
`else
   assign parityFail = 1'b0;
`endif

   assign accept = data_valid && data_ready;
   assign busy   = (state != IDLE);

   generate
      if (DATA_W == 1) begin : g_single
         assign shiftNext = serial_in;
      end else if (LSB_FIRST) begin : g_lsb
         assign shiftNext = {serial_in, shiftReg[DATA_W-1:1]};
      end else begin : g_msb
         assign shiftNext = {shiftReg[DATA_W-2:0], serial_in};
      end
   endgenerate

   // Framing FSM; the stop verdict is registered into commitGood/commitBad so
   // the output stage acts one cycle later while a new frame can already start.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         bitCnt     <= '0;
         shiftReg   <= '0;
         commitGood <= 1'b0;
         commitBad  <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
         parityBad       <= 1'b0;
         commitParityBad <= 1'b0;
`endif
      end else begin
         commitGood <= 1'b0;
         commitBad  <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
         commitParityBad <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (!serial_in) begin
                  state  <= DATA;
                  bitCnt <= '0;
               end
            end
            DATA: begin
               shiftReg <= shiftNext;
               bitCnt   <= bitCnt + 1'b1;
               if (bitCnt == LAST_BIT) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                  state <= PARITY;
`else
                  state <= STOP;
`endif
               end
            end
`ifdef SERIAL_FRAME_RX_PARITY_EN
            PARITY: begin
               parityBad <= (^shiftReg) ^ serial_in;
               state     <= STOP;
            end
`endif
            STOP: begin
               state      <= IDLE;
               commitGood <= serial_in && !parityFail;
               commitBad  <= !serial_in || parityFail;
`ifdef SERIAL_FRAME_RX_PARITY_EN
               commitParityBad <= parityBad;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Holding register; shiftReg is untouched during the commit cycle (IDLE).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         frame_err <= commitBad;
`ifdef SERIAL_FRAME_RX_PARITY_EN
         parity_err <= commitParityBad;
`endif
         if (commitGood && (!data_valid || accept)) begin
            data_out   <= shiftReg;
            data_valid <= 1'b1;
         end else if (accept) begin
            data_valid <= 1'b0;
         end

         if (commitGood && data_valid && !accept) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire
